// File: rtl/stopwatch_counter_if.sv
// Control and display bundle between Ctl, the stopwatch counter and the display path.
interface stopwatch_counter_if;
    logic       init_regs;
    logic       count_enabled;
    logic [3:0] dig_hund;
    logic [3:0] dig_tenth;
    logic [3:0] dig_sec;
    logic [3:0] dig_tsec;
    logic       tick;
    logic       wrap;

    modport master (
        output init_regs, count_enabled,
        input  dig_hund, dig_tenth, dig_sec, dig_tsec, tick, wrap
    );
    modport slave (
        input  init_regs, count_enabled,
        output dig_hund, dig_tenth, dig_sec, dig_tsec, tick, wrap
    );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping: prescaler plus a four-digit BCD ripple counter SS.hh.
module stopwatch_digit (
    input  logic       clk,
    input  logic       clr,
    input  logic       adv,
    output logic [3:0] digit,
    output logic       carry
);
    assign carry = adv && (digit == 4'd9);

    always_ff @(posedge clk) begin
        if (clr)
            digit <= 4'd0;
        else if (adv)
            digit <= carry ? 4'd0 : digit + 4'd1;
    end
endmodule

module stopwatch_counter #(
    parameter int TICK_DIV = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    stopwatch_counter_if.slave sw
);
    localparam int NUM_DIGITS = 4;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]                   p;
    logic                            clr;
    logic                            expire;
    logic [NUM_DIGITS:0]             chain;
    logic [NUM_DIGITS-1:0][3:0]      digs;
    logic                            tick_q;
    logic                            wrap_q;

    // init shares the reset clear; both beat a coincident prescaler expiry
    assign clr      = reset | sw.init_regs;
    assign expire   = sw.count_enabled && (p == PW'(TICK_DIV - 1));
    assign chain[0] = expire;

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
            stopwatch_digit u_digit (
                .clk   (clk),
                .clr   (clr),
                .adv   (chain[g]),
                .digit (digs[g]),
                .carry (chain[g+1])
            );
        end
    endgenerate

    // paused cycles hold p so a resumed hundredth keeps its partial count
    always_ff @(posedge clk) begin
        if (clr) begin
            p      <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else if (sw.count_enabled) begin
            p      <= expire ? '0 : p + PW'(1);
            tick_q <= expire;
            wrap_q <= chain[NUM_DIGITS];
        end else begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end
    end

    assign sw.dig_hund  = digs[0];
    assign sw.dig_tenth = digs[1];
    assign sw.dig_sec   = digs[2];
    assign sw.dig_tsec  = digs[3];
    assign sw.tick      = tick_q;
    assign sw.wrap      = wrap_q;
endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter with TICK_DIV=4 and directed sequences.
module tb_stopwatch_counter;
    localparam int TD = 4;

    typedef struct packed {
        logic [15:0] digs;
        logic        tick;
        logic        wrap;
    } exp_t;

    logic clk;
    logic reset;
    stopwatch_counter_if sw ();

    stopwatch_counter #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   tick_cnt = 0;
    int   wrap_cnt = 0;

    // reference state: value in hundredths, prescaler count
    int m_v = 0;
    int m_p = 0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [15:0] dut_digs();
        return {sw.dig_tsec, sw.dig_sec, sw.dig_tenth, sw.dig_hund};
    endfunction

    // monitor: pops one expectation per clock and compares
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (sw.tick) tick_cnt++;
                if (sw.wrap) wrap_cnt++;
                if (dut_digs() !== e.digs || sw.tick !== e.tick || sw.wrap !== e.wrap) begin
                    n_err++;
                    if (n_err <= 20)
                        $display("FAIL cycle t=%0t: got digs=%h tick=%b wrap=%b, want digs=%h tick=%b wrap=%b",
                                 $time, dut_digs(), sw.tick, sw.wrap, e.digs, e.tick, e.wrap);
                end
            end
        end
    end

    task automatic step(input logic r, input logic ini, input logic en);
        exp_t e;
        reset = r;
        sw.init_regs = ini;
        sw.count_enabled = en;
        @(posedge clk);
        #1;
        e.tick = 1'b0;
        e.wrap = 1'b0;
        if (r || ini) begin
            m_v = 0;
            m_p = 0;
        end else if (en) begin
            if (m_p == TD - 1) begin
                m_p = 0;
                e.tick = 1'b1;
                e.wrap = (m_v == 9999);
                m_v = (m_v + 1) % 10000;
            end else begin
                m_p++;
            end
        end
        e.digs = to_bcd(m_v);
        q.push_back(e);
    endtask

    task automatic run(input int n, input logic en);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, en);
    endtask

    // hand-computed spot check against the DUT outputs right now
    task automatic check(input string name, input logic [15:0] d, input logic t, input logic w);
        n_vec++;
        if (dut_digs() !== d || sw.tick !== t || sw.wrap !== w) begin
            n_err++;
            $display("FAIL %s: got digs=%h tick=%b wrap=%b, want digs=%h tick=%b wrap=%b",
                     name, dut_digs(), sw.tick, sw.wrap, d, t, w);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        sw.init_regs = 1'b0;
        sw.count_enabled = 1'b1;

        // reset held with enable high
        step(1'b1, 1'b0, 1'b1);
        check("reset_c1", 16'h0000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("reset_c2", 16'h0000, 1'b0, 1'b0);

        // 40 enabled cycles -> 10 ticks, 00.10
        step(1'b0, 1'b1, 1'b0);
        drain();
        tick_cnt = 0;
        run(3, 1'b1);
        check("first_latency_pre", 16'h0000, 1'b0, 1'b0);
        run(1, 1'b1);
        check("first_latency_tick", 16'h0001, 1'b1, 1'b0);
        run(36, 1'b1);
        check("count_final", 16'h0010, 1'b1, 1'b0);
        drain();
        check_int("count_ticks", tick_cnt, 10);

        // pause/resume keeps partial hundredth
        step(1'b0, 1'b1, 1'b0);
        run(6, 1'b1);
        check("pause_pre", 16'h0001, 1'b0, 1'b0);
        drain();
        tick_cnt = 0;
        run(20, 1'b0);
        check("pause_hold", 16'h0001, 1'b0, 1'b0);
        drain();
        check_int("pause_no_tick", tick_cnt, 0);
        run(1, 1'b1);
        check("resume_1", 16'h0001, 1'b0, 1'b0);
        run(1, 1'b1);
        check("resume_2", 16'h0002, 1'b1, 1'b0);

        // init mid-count at 00.07, p=2
        step(1'b0, 1'b1, 1'b0);
        run(30, 1'b1);
        check("mid_pre", 16'h0007, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("mid_init", 16'h0000, 1'b0, 1'b0);
        run(3, 1'b1);
        check("mid_3", 16'h0000, 1'b0, 1'b0);
        run(1, 1'b1);
        check("mid_4", 16'h0001, 1'b1, 1'b0);

        // clear colliding with prescaler expiry
        step(1'b0, 1'b1, 1'b0);
        run(7, 1'b1);
        check("coll_pre", 16'h0001, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("coll_init", 16'h0000, 1'b0, 1'b0);
        run(7, 1'b1);
        check("coll_pre2", 16'h0001, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("coll_reset", 16'h0000, 1'b0, 1'b0);

        // run to 99.99 then wrap
        step(1'b0, 1'b1, 1'b0);
        run(39996, 1'b1);
        check("wrap_pre", 16'h9999, 1'b1, 1'b0);
        drain();
        wrap_cnt = 0;
        run(3, 1'b1);
        check("wrap_hold", 16'h9999, 1'b0, 1'b0);
        run(1, 1'b1);
        check("wrap_edge", 16'h0000, 1'b1, 1'b1);
        run(1, 1'b1);
        check("wrap_after", 16'h0000, 1'b0, 1'b0);
        drain();
        check_int("wrap_count", wrap_cnt, 1);
        check_int("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
